wrr_burst_arbiter: RTL and testbench

// - Shares one downstream resource (bus/port) among N requesters, weighted round-robin.
// - Grant is held for a burst of up to W transfers (per-requester weight), released on final

---
 rtl/wrr_burst_arbiter_pkg.sv | 22 ++
 rtl/wrr_burst_arbiter_if.sv | 27 ++
 rtl/wrr_burst_arbiter_rr_pick.sv | 31 +++
 rtl/wrr_burst_arbiter.sv | 114 +++++++++++
 tb/tb_wrr_burst_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/wrr_burst_arbiter_pkg.sv
// Shared types and constants for the weighted round-robin burst arbiter.
package arb_pkg;

    // Arbiter FSM: waiting for a request, or holding a grant for a burst.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Watchdog timer width; TO_CYC must fit (1..2^TMR_W-1).
    localparam int TMR_W = 8;

    // Default geometry and the matching index width.
    localparam int N_DEF    = 4;
    localparam int ID_W_DEF = $clog2(N_DEF);

    // Index width for an N-way arbiter; keeps a 1-bit index for degenerate sizes.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wrr_burst_arbiter_if.sv
// Requester/resource bundle for the arbiter. The arbiter uses the slave
// modport; the requester side (or a bench) uses master.
interface wrr_burst_arbiter_if #(
    parameter int N    = 4,
    parameter int WT_W = 4
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]      req;
    logic [N*WT_W-1:0] weight;
    logic              done;
    logic [N-1:0]      gnt;
    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_id;
    logic              to_err;

    modport master (
        output req, weight, done,
        input  gnt, gnt_valid, gnt_id, to_err
    );

    modport slave (
        input  req, weight, done,
        output gnt, gnt_valid, gnt_id, to_err
    );

endinterface

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// Rotating-priority picker: first requester strictly after last_ptr,
// wrapping mod N; last_ptr itself has lowest priority. Pure combinational.
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_ptr,
    output logic [ID_W-1:0] idx,
    output logic            found
);
    // One spare bit so last_ptr+k (k<=N) never overflows before the wrap.
    logic [ID_W:0] cand;

    // Walk candidates last_ptr+1 .. last_ptr+N, keep the first requester.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(N))
                cand = cand - (ID_W+1)'(N);
            if (!found && req[cand[ID_W-1:0]]) begin
                found = 1'b1;
                idx   = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter. A winner keeps the grant for up to
// weight_i done pulses, and loses it early if it drops req or the watchdog
// sees TO_CYC granted cycles without a done. Every release forces one idle
// bubble before the next grant. All outputs come straight from flops.
import arb_pkg::*;

module wrr_burst_arbiter #(
    parameter int N      = 4,
    parameter int WT_W   = 4,
    parameter int TO_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    wrr_burst_arbiter_if.slave  bus
);
    localparam int ID_W = id_w(N);

    state_e            state, state_nxt;
    logic [N-1:0]      gnt_q, gnt_nxt;
    logic              vld_q, vld_nxt;
    logic [ID_W-1:0]   id_q, id_nxt;
    logic              to_err_q, to_err_nxt;
    logic [ID_W-1:0]   last_ptr, last_ptr_nxt;
    logic [WT_W-1:0]   credit, credit_nxt;
    logic [TMR_W-1:0]  timer, timer_nxt;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_found;
    logic [WT_W-1:0]   pick_wt;

    rr_pick #(.N(N), .ID_W(ID_W)) u_pick (
        .req      (bus.req),
        .last_ptr (last_ptr),
        .idx      (pick_idx),
        .found    (pick_found)
    );

    assign pick_wt = bus.weight[pick_idx*WT_W +: WT_W];

    // State register; reset wins over any grant in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
            id_q     <= '0;
            to_err_q <= 1'b0;
            last_ptr <= ID_W'(N-1);
            credit   <= '0;
            timer    <= '0;
        end else begin
            state    <= state_nxt;
            gnt_q    <= gnt_nxt;
            vld_q    <= vld_nxt;
            id_q     <= id_nxt;
            to_err_q <= to_err_nxt;
            last_ptr <= last_ptr_nxt;
            credit   <= credit_nxt;
            timer    <= timer_nxt;
        end
    end

    // Next-state: grant from IDLE, burst/abandon/watchdog handling in BUSY.
    always_comb begin
        state_nxt    = state;
        gnt_nxt      = gnt_q;
        vld_nxt      = vld_q;
        id_nxt       = id_q;
        to_err_nxt   = 1'b0;
        last_ptr_nxt = last_ptr;
        credit_nxt   = credit;
        timer_nxt    = timer;
        unique case (state)
            IDLE: begin
                // done is meaningless here; only a pending request matters.
                if (pick_found) begin
                    state_nxt    = BUSY;
                    gnt_nxt      = N'(1) << pick_idx;
                    vld_nxt      = 1'b1;
                    id_nxt       = pick_idx;
                    last_ptr_nxt = pick_idx;
                    credit_nxt   = (pick_wt == '0) ? WT_W'(1) : pick_wt;
                    timer_nxt    = '0;
                end
            end
            BUSY: begin
                if (!bus.req[id_q] || (bus.done && credit == WT_W'(1))) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    vld_nxt   = 1'b0;
                    id_nxt    = '0;
                end else if (bus.done) begin
                    credit_nxt = credit - WT_W'(1);
                    timer_nxt  = '0;
                end else if (timer == TMR_W'(TO_CYC-1)) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    vld_nxt    = 1'b0;
                    id_nxt     = '0;
                    to_err_nxt = 1'b1;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = vld_q;
    assign bus.gnt_id    = id_q;
    assign bus.to_err    = to_err_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: constant-expectation vector table, short
// multi-cycle sequences, then randomized traffic, all shadowed cycle by cycle
// by a behavioural model of who owns the resource.
module tb_wrr_burst_arbiter;
    localparam int N    = 4;
    localparam int WT_W = 4;
    localparam int TO   = 15;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    wrr_burst_arbiter_if #(.N(N), .WT_W(WT_W)) bus ();

    wrr_burst_arbiter #(.N(N), .WT_W(WT_W), .TO_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner index (-1 = nobody), remaining burst credit,
    // cycles since grant or last done, and the previous winner.
    int m_owner;
    int m_last;
    int m_credit;
    int m_quiet;
    int m_to_err;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wt_of(input int i);
        int w;
        w = int'(bus.weight[i*WT_W +: WT_W]);
        return (w == 0) ? 1 : w;
    endfunction

    // One clock edge of the reference behaviour, using inputs seen at that edge.
    task automatic model_step();
        m_to_err = 0;
        if (rst) begin
            m_owner  = -1;
            m_last   = N - 1;
            m_credit = 0;
            m_quiet  = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && bus.req[c]) begin
                    m_owner  = c;
                    m_last   = c;
                    m_credit = wt_of(c);
                    m_quiet  = 0;
                end
            end
        end else if (!bus.req[m_owner]) begin
            m_owner = -1;
        end else if (bus.done) begin
            m_credit--;
            m_quiet = 0;
            if (m_credit == 0) m_owner = -1;
        end else begin
            m_quiet++;
            if (m_quiet == TO) begin
                m_owner  = -1;
                m_to_err = 1;
            end
        end
    endtask

    // Advance one edge, then compare every output against the model.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("gnt",       int'(bus.gnt),       (m_owner < 0) ? 0 : (1 << m_owner));
        chk("gnt_valid", int'(bus.gnt_valid), (m_owner < 0) ? 0 : 1);
        chk("gnt_id",    int'(bus.gnt_id),    (m_owner < 0) ? 0 : m_owner);
        chk("to_err",    int'(bus.to_err),    m_to_err);
        chk("onehot",    int'($countones(bus.gnt) <= 1), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.req = '0; bus.done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] exp_gnt;
        logic         exp_to;
    } vec_t;

    vec_t tbl[16];

    initial begin
        rst = 1'b1; bus.req = '0; bus.done = 1'b0; bus.weight = 16'h1111;
        m_owner = -1; m_last = N - 1; m_credit = 0; m_quiet = 0; m_to_err = 0;

        // Reset, idle for 5 cycles, then weight-1 rotation with done each grant.
        tbl[0] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0};
        for (int i = 1; i <= 5; i++) tbl[i] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0};
        tbl[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 1'b0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0};
        tbl[12] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 1'b0};
        tbl[13] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0};
        tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b0};
        tbl[15] = '{1'b0, 4'b1111, 1'b1, 4'b0000, 1'b0};

        for (int i = 0; i < 16; i++) begin
            rst = tbl[i].rst; bus.req = tbl[i].req; bus.done = tbl[i].done;
            tick();
            chk($sformatf("tbl%0d_gnt", i), int'(bus.gnt), int'(tbl[i].exp_gnt));
            chk($sformatf("tbl%0d_to", i), int'(bus.to_err), int'(tbl[i].exp_to));
        end

        // Weight 3 burst: held across three spaced dones, then pointer moves on.
        do_reset();
        bus.weight = 16'h3111;
        bus.req = 4'b1000; bus.done = 1'b0;
        tick(); chk("w3_grant", int'(bus.gnt), 4'b1000);
        for (int d = 0; d < 3; d++) begin
            bus.done = 1'b0; tick();
            chk("w3_hold", int'(bus.gnt), 4'b1000);
            bus.done = 1'b1; tick();
            chk("w3_after_done", int'(bus.gnt), (d == 2) ? 0 : 4'b1000);
        end
        bus.done = 1'b0; bus.req = 4'b1001;
        tick(); chk("w3_next", int'(bus.gnt), 4'b0001);

        // Watchdog: 15 granted cycles without done, one-cycle to_err, regrant.
        do_reset();
        bus.weight = 16'h1111; bus.req = 4'b0010;
        tick(); chk("to_grant", int'(bus.gnt), 4'b0010);
        for (int c = 1; c < TO; c++) begin
            tick(); chk("to_hold", int'(bus.gnt), 4'b0010);
        end
        tick();
        chk("to_release", int'(bus.gnt), 0);
        chk("to_err_pulse", int'(bus.to_err), 1);
        tick();
        chk("to_regrant", int'(bus.gnt), 4'b0010);
        chk("to_err_clear", int'(bus.to_err), 0);

        // Requester abandons its grant.
        do_reset();
        bus.req = 4'b0110;
        tick(); chk("drop_grant", int'(bus.gnt), 4'b0010);
        bus.req = 4'b0100; bus.done = 1'b1;
        tick(); chk("drop_release", int'(bus.gnt), 0);
        bus.done = 1'b0;
        tick(); chk("drop_next", int'(bus.gnt), 4'b0100);

        // Reset mid-burst, then pointer restarts from N-1.
        do_reset();
        bus.weight = 16'h1211; bus.req = 4'b0100;
        tick(); chk("rst_grant", int'(bus.gnt), 4'b0100);
        rst = 1'b1;
        tick();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_vld", int'(bus.gnt_valid), 0);
        chk("rst_id", int'(bus.gnt_id), 0);
        rst = 1'b0; bus.req = 4'b1111;
        tick(); chk("rst_first", int'(bus.gnt), 4'b0001);

        // Randomized traffic against the model; done density changes by phase.
        for (int ph = 0; ph < 10; ph++) begin
            int done_pct;
            done_pct = (ph % 3 == 0) ? 0 : ((ph % 3 == 1) ? 30 : 70);
            for (int c = 0; c < 200; c++) begin
                rst = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 3) == 0) bus.req = N'($urandom_range(0, 15));
                if ($urandom_range(0, 19) == 0) bus.weight = 16'($urandom & 32'h3333);
                bus.done = ($urandom_range(0, 99) < done_pct);
                tick();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
